pll_rst_gen: RTL and testbench

Lock-qualified reset generator that sits directly downstream of the PLL wrapper. It consumes the PLL `locked` flag, which is asynchronous to `sys_clk`, and synchronises it. It requires `locked` to stay stable for a programmable time, then holds reset for a further programmable time before releasing a clean, synchronously deasserted active-low reset to the rest of the design. Loss of lock re-asserts reset immediately, and the block counts lock-loss events.

---
 rtl/pll_rst_pkg.sv | 15 +
 rtl/sync_bit.sv | 21 ++
 rtl/pll_rst_gen.sv | 119 +++++++++++
 tb/tb_pll_rst_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared FSM state enum and lock-loss counter sizing
// for the PLL lock-qualified reset generator.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } pll_state_e;

  localparam int              LOST_CNT_W   = 8;
  localparam logic [7:0]      LOST_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-stage single-bit synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_gen.sv
// pll_rst_gen: qualifies PLL locked, holds then releases rst_n_out/ready,
// pulses lock_lost on loss from HOLD/RUN; lost_cnt built with PLL_RST_LOST_CNT_EN.
module pll_rst_gen
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1000,
  parameter int RST_HOLD_CYC    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  locked,
  output logic                  rst_n_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam int CNT_MAX =
    (LOCK_STABLE_CYC > RST_HOLD_CYC) ?
    LOCK_STABLE_CYC : RST_HOLD_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  // The WAIT_LOCK->STABLE edge is itself the first
  // qualified cycle, so STABLE needs LOCK_STABLE_CYC-1 more.
  localparam int STB_LAST =
    (LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0;
  localparam logic [CNT_W-1:0] STB_END  = CNT_W'(STB_LAST);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD_CYC - 1);

  logic             locked_s;
  pll_state_e       state;
  logic [CNT_W-1:0] cnt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_n_out <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          rst_n_out <= 1'b0;
          cnt       <= '0;
          if (locked_s) begin
            state <= (LOCK_STABLE_CYC == 1) ? HOLD : STABLE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_END) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            lock_lost <= 1'b1;
          end else if (cnt == HOLD_END) begin
            state     <= RUN;
            cnt       <= '0;
            rst_n_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_n_out <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          cnt       <= '0;
          rst_n_out <= 1'b0;
        end
      endcase
    end
  end

  assign ready = rst_n_out;

`ifdef PLL_RST_LOST_CNT_EN
  logic [LOST_CNT_W-1:0] lost_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lost_q <= '0;
    end else if (lock_lost && lost_q != LOST_CNT_MAX) begin
      lost_q <= lost_q + LOST_CNT_W'(1);
    end
  end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_gen.sv
// tb_pll_rst_gen: directed bench for pll_rst_gen with a run-length
// reference model checked every cycle plus literal latency checks.
module tb_pll_rst_gen;

  localparam int SS   = 2;
  localparam int LS   = 8;
  localparam int RH   = 4;
  localparam int RISE = SS + LS + RH;
  localparam int FALL = SS + 1;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       locked    = 1'b0;
  logic       rst_n_out;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lost_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 sys_clk = ~sys_clk;

  pll_rst_gen #(
    .SYNC_STAGES     (SS),
    .LOCK_STABLE_CYC (LS),
    .RST_HOLD_CYC    (RH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .locked    (locked),
    .rst_n_out (rst_n_out),
    .ready     (ready),
    .lock_lost (lock_lost),
    .lost_cnt  (lost_cnt)
  );

  // Reference model: r0..r3 are the lengths of the run of
  // consecutive high samples of locked ending at edges n..n-3.
  // The FSM sees the sample of edge n-2. RUN needs a run of
  // LS+RH; HOLD/RUN was reached iff the prior run was >= LS.
  int r0 = 0, r1 = 0, r2 = 0, r3 = 0;
  int m_rst = 0, m_ll = 0, m_cnt = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r0 = 0; r1 = 0; r2 = 0; r3 = 0;
      m_rst = 0; m_ll = 0; m_cnt = 0;
    end else begin
`ifdef PLL_RST_LOST_CNT_EN
      if (m_ll == 1 && m_cnt < 255) m_cnt++;
`endif
      r3 = r2; r2 = r1; r1 = r0;
      r0 = locked ? ((r0 < 10000) ? r0 + 1 : r0) : 0;
      m_rst = (r2 >= LS + RH) ? 1 : 0;
      m_ll  = (r2 == 0 && r3 >= LS) ? 1 : 0;
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    check("cyc_rst_n_out", int'(rst_n_out), m_rst);
    check("cyc_ready",     int'(ready),     m_rst);
    check("cyc_lock_lost", int'(lock_lost), m_ll);
    check("cyc_lost_cnt",  int'(lost_cnt),  m_cnt);
  end

  task automatic rise_edges(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge sys_clk); #1;
      if (rst_n_out) begin n = i; break; end
    end
  endtask

  task automatic fall_edges(output int n, output int ll);
    n  = -1;
    ll = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge sys_clk); #1;
      if (!rst_n_out) begin
        n  = i;
        ll = int'(lock_lost);
        break;
      end
    end
  endtask

  function automatic int lc(input int v);
`ifdef PLL_RST_LOST_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  int n, ll, pulses, highs;

  initial begin
    #1 sys_rst_n = 1'b0;
    #2;
    check("rst_rst_n_out", int'(rst_n_out), 0);
    check("rst_ready",     int'(ready),     0);
    check("rst_lock_lost", int'(lock_lost), 0);
    check("rst_lost_cnt",  int'(lost_cnt),  0);

    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    locked    = 1'b1;
    rise_edges(n);
    check("rise_first", n, RISE);
    check("rise_ready", int'(ready), 1);

    @(negedge sys_clk);
    locked = 1'b0;
    fall_edges(n, ll);
    check("fall_edges", n, FALL);
    check("fall_pulse", ll, 1);
    @(posedge sys_clk); #1;
    check("fall_pulse_end", int'(lock_lost), 0);
    repeat (2) @(posedge sys_clk); #1;
    check("fall_lost_cnt", int'(lost_cnt), lc(1));

    @(negedge sys_clk);
    locked = 1'b1;
    rise_edges(n);
    check("rise_relock", n, RISE);

    // Second loss from RUN, then a short drop inside STABLE.
    @(negedge sys_clk);
    locked = 1'b0;
    repeat (6) @(negedge sys_clk);
    locked = 1'b1;
    repeat (7) @(negedge sys_clk);
    locked = 1'b0;
    repeat (3) @(negedge sys_clk);
    locked = 1'b1;
    rise_edges(n);
    check("rise_after_stable_drop", n, RISE);
    check("stable_lost_cnt", int'(lost_cnt), lc(2));

    // Loss during HOLD: one pulse, no release.
    @(negedge sys_clk);
    locked = 1'b0;
    repeat (6) @(negedge sys_clk);
    locked = 1'b1;
    repeat (10) @(negedge sys_clk);
    locked = 1'b0;
    pulses = 0;
    highs  = 0;
    repeat (8) begin
      @(posedge sys_clk); #1;
      pulses += int'(lock_lost);
      highs  += int'(rst_n_out);
    end
    check("hold_pulses", pulses, 1);
    check("hold_no_rise", highs, 0);
    check("hold_lost_cnt", int'(lost_cnt), lc(4));

    // 300 further losses from RUN saturate the counter.
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      locked = 1'b1;
      repeat (14) @(negedge sys_clk);
      locked = 1'b0;
      repeat (1) @(negedge sys_clk);
    end
    repeat (4) @(negedge sys_clk);
    check("sat_lost_cnt", int'(lost_cnt), lc(255));

    // Asynchronous reset in RUN.
    locked = 1'b1;
    rise_edges(n);
    check("rise_pre_reset", n, RISE);
    @(negedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst_rst_n_out", int'(rst_n_out), 0);
    check("arst_ready",     int'(ready),     0);
    check("arst_lock_lost", int'(lock_lost), 0);
    check("arst_lost_cnt",  int'(lost_cnt),  0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rise_edges(n);
    check("rise_post_reset", n, RISE);
    check("post_reset_cnt", int'(lost_cnt), 0);

    repeat (3) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
